// File: rtl/joypad_pkg.sv
// Shared constants for the joypad responder.
// Button indices follow the serial read order seen by the host: A is read first.
// Optional feature macro used by the top level: JOYPAD_TURBO_EN.
package joypad_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Shift register width and the count at which bits_read saturates.
  localparam int unsigned SHIFT_W   = 8;
  localparam int unsigned SAT_COUNT = 8;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with rising-edge detector for one asynchronous pin.
// Ports:
//   clk_in    - system clock
//   rst_in    - asynchronous active-high reset; clears all flops
//   d_in      - asynchronous input pin
//   level_out - synchronised level (last synchroniser stage)
//   rise_out  - one-cycle pulse when the synchronised level goes 0 -> 1
// Because the edge flop resets to 0, a pin already high at reset release is
// reported as a rising edge once it reaches the last stage.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic level_out,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_out = sync_q[SYNC_STAGES-1];
  assign rise_out  = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/joypad_responder.sv
// Serial joypad responder: presents captured button state to a host that
// drives latch and shift-clock pins asynchronously to clk_in.
// Ports:
//   clk_in, rst_in   - system clock, asynchronous active-high reset
//   jp_latch_in      - host latch pin (async)
//   jp_clk_in        - host shift clock pin (async)
//   btn_in[7:0]      - button state, 1 = pressed, A..Right = bits 0..7
//   btn_valid_in     - strobe capturing btn_in
//   turbo_in[1:0]    - turbo enable for A/B (only with JOYPAD_TURBO_EN)
//   jp_data_out      - registered serial data pin
//   bits_read_out    - shifts since last latch, saturating at 8
//   frame_done_out   - one-cycle pulse on the 8th shift
// Optional feature: define JOYPAD_TURBO_EN to add turbo on A and B.
module joypad_responder
  import joypad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DATA_ACTIVE_LOW = 1,
  parameter int unsigned TURBO_LATCHES   = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 jp_latch_in,
  input  logic                 jp_clk_in,
  input  logic [SHIFT_W-1:0]   btn_in,
  input  logic                 btn_valid_in,
`ifdef JOYPAD_TURBO_EN
  input  logic [1:0]           turbo_in,
`endif
  output logic                 jp_data_out,
  output logic [3:0]           bits_read_out,
  output logic                 frame_done_out
);

  localparam logic PIN_INVERT = (DATA_ACTIVE_LOW != 0);

  logic               latch_level, latch_rise;
  logic               clk_level, clk_rise;
  logic [SHIFT_W-1:0] btn_q;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               data_q;
  logic [SHIFT_W-1:0] reload_src;
  logic [SHIFT_W-1:0] reload_val;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_latch (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .d_in     (jp_latch_in),
    .level_out(latch_level),
    .rise_out (latch_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_clk (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .d_in     (jp_clk_in),
    .level_out(clk_level),
    .rise_out (clk_rise)
  );

  // A strobe coinciding with a reload bypasses btn_q so the new state is seen at once.
  assign reload_src = btn_valid_in ? btn_in : btn_q;

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned TURBO_W = $clog2(TURBO_LATCHES + 1);

  logic [TURBO_W-1:0] turbo_cnt_q;
  logic               turbo_phase_q;

  // Counts latches 1..TURBO_LATCHES; the latch after the last one flips the
  // phase, so each phase spans exactly TURBO_LATCHES frames.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else if (latch_rise) begin
      if (turbo_cnt_q == TURBO_W'(TURBO_LATCHES)) begin
        turbo_cnt_q   <= TURBO_W'(1);
        turbo_phase_q <= ~turbo_phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + TURBO_W'(1);
      end
    end
  end

  // Phase 0 forces turbo-enabled buttons to read released.
  always_comb begin
    reload_val = reload_src;
    if (!turbo_phase_q) begin
      reload_val[BTN_A] = reload_src[BTN_A] & ~turbo_in[0];
      reload_val[BTN_B] = reload_src[BTN_B] & ~turbo_in[1];
    end
  end
`else
  assign reload_val = reload_src;
`endif

  // Latch has priority over shifting; a latch rise is always accompanied by a
  // high latch level, so an abort mid-frame reloads without a done pulse.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (latch_rise || latch_level) begin
      shift_d = reload_val;
      cnt_d   = '0;
    end else if (clk_rise && clk_level) begin
      // Fill with pressed so reads past the end return pressed.
      shift_d = {1'b1, shift_q[SHIFT_W-1:1]};
      if (cnt_q < 4'(SAT_COUNT)) begin
        cnt_d = cnt_q + 4'd1;
      end
      done_d = (cnt_q == 4'(SAT_COUNT - 1));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      data_q  <= PIN_INVERT;
    end else begin
      if (btn_valid_in) begin
        btn_q <= btn_in;
      end
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      data_q  <= shift_d[0] ^ PIN_INVERT;
    end
  end

  assign jp_data_out    = data_q;
  assign bits_read_out  = cnt_q;
  assign frame_done_out = done_q;

endmodule

// File: doc/joypad_responder.md
JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the synchroniser for jp_clk_in and jp_latch_in; legal values 2..4.
REQ-002 Parameter DATA_ACTIVE_LOW, default 1: when 1, jp_data_out is low for a pressed button; when 0, it is high for a pressed button.
REQ-003 Parameter TURBO_LATCHES, default 2: number of latch rising edges per turbo phase; used only when JOYPAD_TURBO_EN is defined.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 jp_latch_in  input  1  latch from the host; asynchronous to clk_in.
REQ-007 jp_clk_in  input  1  shift clock from the host; asynchronous to clk_in.
REQ-008 btn_in  input  8  button state, 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right = bits 0..7.
REQ-009 btn_valid_in  input  1  single-cycle strobe that captures btn_in.
REQ-010 jp_data_out  output  1  serial button data to the host; registered.
REQ-011 bits_read_out  output  4  count of shifts since the last latch, saturating at 8.
REQ-012 frame_done_out  output  1  one-cycle pulse when the 8th bit has been shifted out.

Function
REQ-013 The block SHALL synchronise jp_latch_in and jp_clk_in through SYNC_STAGES flops each, then edge-detect them against one additional flop.
REQ-014 The block SHALL hold btn_q[7:0], which is loaded from btn_in on each cycle where btn_valid_in=1.
REQ-015 While the synchronised latch is high, the shift register SHALL reload from btn_q every cycle. If btn_valid_in is high in that same cycle, the reload SHALL take btn_in directly (bypass).
REQ-016 While the latch is high, bits_read_out SHALL be 0 and jp_clk_in edges SHALL be ignored.
REQ-017 On a synchronised jp_clk_in rising edge while the latch is low, the block SHALL:
  - shift the register right by one;
  - fill bit 7 with logical 1 (pressed);
  - increment bits_read_out, saturating at 8.
REQ-018 After 8 or more shifts, jp_data_out SHALL present logical 1 (pressed) until the next latch.
REQ-019 The pin level of jp_data_out SHALL be shift_reg[0] XOR DATA_ACTIVE_LOW.
REQ-020 frame_done_out SHALL pulse for one cycle on the shift that moves bits_read_out from 7 to 8, and never on later shifts.
REQ-021 A latch rising edge in the middle of a frame SHALL abort the frame: reload and zero the count immediately, with no frame_done_out pulse.
REQ-022 The shift register SHALL update no later than SYNC_STAGES+1 clk_in cycles after a pin edge.
REQ-023 If latch and clk edges are detected in the same cycle, the latch SHALL win.
REQ-024 Pulses on either input shorter than 2 clk_in periods are unsupported; behaviour for them is not defined.

Reset
REQ-025 While rst_in is high, the block SHALL hold:
  - btn_q = 0 and shift register = 0 (all released);
  - bits_read_out = 0, frame_done_out = 0;
  - jp_data_out = DATA_ACTIVE_LOW (released level);
  - synchroniser and edge flops = 0;
  - turbo state = 0.
REQ-026 On reset deassertion, the block SHALL treat an input that is already high as a rising edge on the first synchronised cycle.

Configuration
REQ-027 Macro JOYPAD_TURBO_EN SHALL add input turbo_in[1:0], which enables turbo on A (bit 0) and B (bit 1).
REQ-028 With JOYPAD_TURBO_EN defined:
  - a phase counter SHALL toggle a turbo phase every TURBO_LATCHES latch rising edges;
  - during phase 0, a turbo-enabled pressed button SHALL be loaded as released.
REQ-029 Without JOYPAD_TURBO_EN, there SHALL be no turbo_in port, no turbo logic, and btn_q SHALL be loaded unmodified.

Structure
REQ-030 Package joypad_pkg SHALL hold the button index constants (BTN_A..BTN_RIGHT), the shift width constant 8, and the saturation constant 8.
REQ-031 Sub-module sync_edge (SYNC_STAGES synchroniser plus rise detector) SHALL be instantiated once for latch and once for clk.

Verification
REQ-032 Reset check: hold rst_in high, then release -> jp_data_out=1, bits_read_out=0, no frame_done_out pulse.
REQ-033 Basic read: btn_in=8'b0000_1001 with strobe, latch pulse, 8 clk pulses -> pin sequence 0,1,1,0,1,1,1,1, then frame_done_out pulses once and bits_read_out=8.
REQ-034 Past-end reads: 12 clk pulses after a latch -> pins 9..12 read 0 (pressed), with only one frame_done_out pulse.
REQ-035 Mid-frame latch: latch pulse after 3 clk pulses -> bits_read_out=0, bit A presented again, no frame_done_out pulse.
REQ-036 Bypass: btn_valid_in with btn_in=8'h01 in the same cycle as the latch-high reload -> first bit reads pressed.
REQ-037 Turbo (with JOYPAD_TURBO_EN, TURBO_LATCHES=2, turbo_in=2'b01, A held) -> A alternates 2 frames released, 2 frames pressed.
